mdom_bsum_engine: RTL and testbench

MDOM_BSUM_ENGINE -- requirements
Module: mDOM_bsum_engine

---
 rtl/mdom_bsum_engine.sv | 167 ++++++++++++++++
 tb/tb_mdom_bsum_engine.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mdom_bsum_engine.sv
// Baseline-sum engine: averages ADC samples over power-of-two blocks and
// suspends accumulation for a programmable number of samples after an excursion.
module mdom_bsum_engine (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [44:0] i_bundle,
    input  logic [11:0] i_adc_data,
    input  logic        i_adc_valid,
    output logic [11:0] o_bsum,
    output logic        o_bsum_valid,
    output logic        o_bsum_stb,
    output logic        o_paused
);

    typedef enum logic {ST_ACCUM, ST_PAUSE} state_t;

    state_t      r_state;
    state_t      w_stateNext;
    logic [21:0] r_acc;
    logic [9:0]  r_count;
    logic [15:0] r_pauseCnt;
    logic [2:0]  r_sel;
    logic [11:0] r_bsum;
    logic        r_bsumValid;
    logic        r_bsumStb;
    logic        r_paused;

    logic        w_pause;
    logic        w_override;
    logic [2:0]  w_selLive;
    logic [15:0] w_pauseLen;
    logic [11:0] w_devLow;
    logic [11:0] w_devHigh;

    logic [2:0]  w_blkSel;
    logic [3:0]  w_shift;
    logic [10:0] w_blkLen;
    logic [9:0]  w_lastCnt;
    logic [21:0] w_sum;
    logic [11:0] w_avg;
    logic [11:0] w_lowThr;
    logic [12:0] w_highSum;
    logic [11:0] w_highThr;
    logic        w_isDev;

    logic        w_accept;
    logic        w_clear;
    logic        w_loadPause;
    logic        w_decPause;
    logic        w_complete;

    assign w_pause    = i_bundle[0];
    assign w_override = i_bundle[1];
    assign w_selLive  = i_bundle[4:2];
    assign w_pauseLen = i_bundle[20:5];
    assign w_devLow   = i_bundle[32:21];
    assign w_devHigh  = i_bundle[44:33];

    // Block length is fixed by the select value seen at the block's first sample.
    assign w_blkSel  = (r_count == 10'd0) ? w_selLive : r_sel;
    assign w_shift   = {1'b0, w_blkSel} + 4'd3;
    assign w_blkLen  = 11'd1 << w_shift;
    assign w_lastCnt = 10'(w_blkLen - 11'd1);
    assign w_sum     = r_acc + 22'(i_adc_data);
    assign w_avg     = 12'(w_sum >> w_shift);

    // Thresholds saturate at the ADC range so the strict compares never wrap.
    assign w_lowThr  = (r_bsum > w_devLow) ? (r_bsum - w_devLow) : 12'd0;
    assign w_highSum = {1'b0, r_bsum} + {1'b0, w_devHigh};
    assign w_highThr = w_highSum[12] ? 12'hFFF : w_highSum[11:0];
    assign w_isDev   = r_bsumValid && !w_override &&
                       ((i_adc_data < w_lowThr) || (i_adc_data > w_highThr));

    always_comb begin
        w_stateNext = r_state;
        w_accept    = 1'b0;
        w_clear     = 1'b0;
        w_loadPause = 1'b0;
        w_decPause  = 1'b0;
        if (w_pause) begin
            w_clear = 1'b1;
        end else begin
            case (r_state)
                ST_ACCUM: begin
                    if (i_adc_valid) begin
                        if (w_isDev) begin
                            w_clear     = 1'b1;
                            w_loadPause = 1'b1;
                            w_stateNext = ST_PAUSE;
                        end else begin
                            w_accept = 1'b1;
                        end
                    end
                end
                ST_PAUSE: begin
                    // An exhausted counter resumes at once; a sample arriving then is kept.
                    if (r_pauseCnt == 16'd0) begin
                        w_stateNext = ST_ACCUM;
                        w_accept    = i_adc_valid;
                    end else if (i_adc_valid) begin
                        w_decPause = 1'b1;
                    end
                end
                default: w_stateNext = ST_ACCUM;
            endcase
        end
    end

    assign w_complete = w_accept && (r_count == w_lastCnt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_ACCUM;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc   <= 22'd0;
            r_count <= 10'd0;
            r_sel   <= 3'd0;
        end else if (w_clear || w_complete) begin
            r_acc   <= 22'd0;
            r_count <= 10'd0;
        end else if (w_accept) begin
            r_acc   <= w_sum;
            r_count <= r_count + 10'd1;
            if (r_count == 10'd0) begin
                r_sel <= w_selLive;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pauseCnt <= 16'd0;
        end else if (w_loadPause) begin
            r_pauseCnt <= w_pauseLen;
        end else if (w_decPause) begin
            r_pauseCnt <= r_pauseCnt - 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bsum      <= 12'd0;
            r_bsumValid <= 1'b0;
            r_bsumStb   <= 1'b0;
            r_paused    <= 1'b0;
        end else begin
            r_bsumStb <= w_complete;
            r_paused  <= w_pause || (w_stateNext == ST_PAUSE);
            if (w_complete) begin
                r_bsum      <= w_avg;
                r_bsumValid <= 1'b1;
            end
        end
    end

    assign o_bsum       = r_bsum;
    assign o_bsum_valid = r_bsumValid;
    assign o_bsum_stb   = r_bsumStb;
    assign o_paused     = r_paused;

endmodule

// File: tb/tb_mdom_bsum_engine.sv
// Self-checking bench for mdom_bsum_engine: a block-list reference model checked
// every cycle, plus directed scenarios with hand-computed literal results.
module tb_mdom_bsum_engine;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [44:0] bundle = '0;
    logic [11:0] adcData = '0;
    logic        adcValid = 1'b0;
    logic [11:0] bsum;
    logic        bsumValid;
    logic        bsumStb;
    logic        paused;

    int vectors = 0;
    int miscompares = 0;

    mdom_bsum_engine dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_bundle     (bundle),
        .i_adc_data   (adcData),
        .i_adc_valid  (adcValid),
        .o_bsum       (bsum),
        .o_bsum_valid (bsumValid),
        .o_bsum_stb   (bsumStb),
        .o_paused     (paused)
    );

    always #5 clk = ~clk;

    // Reference model: the current block is a list of kept samples, averaged when full.
    int expBsum = 0;
    int expValid = 0;
    int expStb = 0;
    int expPaused = 0;
    int inPause = 0;
    int pauseLeft = 0;
    int blkSel = 0;
    int blk[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            expBsum = 0; expValid = 0; expStb = 0; expPaused = 0;
            inPause = 0; pauseLeft = 0; blkSel = 0;
            blk.delete();
        end else begin
            int d, lo, hi, sum;
            bit dev;
            d = adcData;
            expStb = 0;
            if (bundle[0]) begin
                blk.delete();
                expPaused = 1;
            end else begin
                if (inPause != 0) begin
                    if (pauseLeft == 0) begin
                        inPause = 0;
                        if (adcValid) begin
                            if (blk.size() == 0) blkSel = bundle[4:2];
                            blk.push_back(d);
                        end
                    end else if (adcValid) begin
                        pauseLeft--;
                    end
                end else if (adcValid) begin
                    dev = 0;
                    if (expValid != 0 && !bundle[1]) begin
                        lo = expBsum - int'(bundle[32:21]);
                        if (lo < 0) lo = 0;
                        hi = expBsum + int'(bundle[44:33]);
                        if (hi > 4095) hi = 4095;
                        dev = (d < lo) || (d > hi);
                    end
                    if (dev) begin
                        blk.delete();
                        pauseLeft = bundle[20:5];
                        inPause = 1;
                    end else begin
                        if (blk.size() == 0) blkSel = bundle[4:2];
                        blk.push_back(d);
                        if (blk.size() == (1 << (blkSel + 3))) begin
                            sum = 0;
                            foreach (blk[i]) sum += blk[i];
                            expBsum = sum >> (blkSel + 3);
                            expStb = 1;
                            expValid = 1;
                            blk.delete();
                        end
                    end
                end
                expPaused = inPause;
            end
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        checkOutput("model bsum", int'(bsum), expBsum);
        checkOutput("model bsum_valid", int'(bsumValid), expValid);
        checkOutput("model bsum_stb", int'(bsumStb), expStb);
        checkOutput("model paused", int'(paused), expPaused);
    end

    task automatic setCfg(input bit p, input bit ovr, input int sel, input int plen,
                          input int dlow, input int dhigh);
        bundle = {12'(dhigh), 12'(dlow), 16'(plen), 3'(sel), ovr, p};
    endtask

    // Presents n back-to-back samples of value d; returns on the negedge after the last.
    task automatic applyStimulus(input int d, input int n);
        for (int k = 0; k < n; k++) begin
            adcData = 12'(d);
            adcValid = 1'b1;
            @(negedge clk);
        end
        adcValid = 1'b0;
    endtask

    initial begin
        setCfg(0, 0, 0, 3, 10, 10);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset bsum", int'(bsum), 0);
        checkOutput("reset bsum_valid", int'(bsumValid), 0);
        checkOutput("reset paused", int'(paused), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // First block of 8 x 100.
        applyStimulus(100, 8);
        checkOutput("block8 bsum", int'(bsum), 100);
        checkOutput("block8 stb", int'(bsumStb), 1);
        checkOutput("block8 valid", int'(bsumValid), 1);
        @(negedge clk);
        checkOutput("block8 stb width", int'(bsumStb), 0);

        // 111 exceeds 100+10: three samples dropped, then resume.
        applyStimulus(111, 1);
        checkOutput("dev paused", int'(paused), 1);
        applyStimulus(200, 3);
        checkOutput("dev still paused", int'(paused), 1);
        applyStimulus(104, 1);
        checkOutput("dev resumed", int'(paused), 0);
        applyStimulus(104, 7);
        checkOutput("post-pause bsum", int'(bsum), 104);
        checkOutput("post-pause stb", int'(bsumStb), 1);

        // Boundary samples at exactly bsum +/- 10 are not deviations.
        applyStimulus(100, 8);
        checkOutput("rebase bsum", int'(bsum), 100);
        applyStimulus(110, 1);
        checkOutput("edge high no pause", int'(paused), 0);
        applyStimulus(90, 1);
        checkOutput("edge low no pause", int'(paused), 0);
        applyStimulus(100, 6);
        checkOutput("edge block bsum", int'(bsum), 100);

        // Override lets a large excursion accumulate: (4000 + 700) / 8.
        setCfg(0, 1, 0, 3, 10, 10);
        applyStimulus(4000, 1);
        checkOutput("override no pause", int'(paused), 0);
        applyStimulus(100, 7);
        checkOutput("override bsum", int'(bsum), 587);

        // Low threshold saturates at zero when bsum < dev_low.
        applyStimulus(5, 8);
        checkOutput("bsum5", int'(bsum), 5);
        setCfg(0, 0, 0, 3, 20, 10);
        applyStimulus(0, 1);
        checkOutput("zero no pause", int'(paused), 0);
        applyStimulus(0, 7);
        checkOutput("zero block bsum", int'(bsum), 0);

        // Select change after the first sample leaves the block at 8.
        setCfg(0, 1, 0, 3, 20, 10);
        applyStimulus(40, 1);
        setCfg(0, 1, 1, 3, 20, 10);
        applyStimulus(40, 7);
        checkOutput("sel latch stb", int'(bsumStb), 1);
        checkOutput("sel latch bsum", int'(bsum), 40);

        // External pause mid-block clears the partial sum and holds bsum.
        setCfg(0, 1, 0, 3, 20, 10);
        applyStimulus(10, 3);
        setCfg(1, 1, 0, 3, 20, 10);
        applyStimulus(3000, 1);
        checkOutput("ext paused", int'(paused), 1);
        applyStimulus(3000, 4);
        checkOutput("ext bsum held", int'(bsum), 40);
        setCfg(0, 1, 0, 3, 20, 10);
        applyStimulus(20, 1);
        checkOutput("ext released", int'(paused), 0);
        applyStimulus(20, 7);
        checkOutput("ext block bsum", int'(bsum), 20);

        // Largest block: 1023 samples give no strobe, the 1024th gives full scale.
        setCfg(0, 1, 7, 3, 20, 10);
        applyStimulus(4095, 1023);
        checkOutput("1023 no stb", int'(bsumStb), 0);
        checkOutput("1023 bsum held", int'(bsum), 20);
        applyStimulus(4095, 1);
        checkOutput("1024 stb", int'(bsumStb), 1);
        checkOutput("1024 bsum", int'(bsum), 4095);

        // Asynchronous reset mid-block.
        setCfg(0, 1, 0, 3, 20, 10);
        applyStimulus(4095, 3);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async rst bsum", int'(bsum), 0);
        checkOutput("async rst valid", int'(bsumValid), 0);
        checkOutput("async rst stb", int'(bsumStb), 0);
        checkOutput("async rst paused", int'(paused), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("post rst valid", int'(bsumValid), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
